// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the level-reporting FIFO family.
package fifo_pkg;

    typedef enum {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_level_chk.sv
// Structural invariants of fifo_level: pointer stability on rejected requests and flag consistency.
module fifo_level_chk #(
    parameter int DEPTH = 16,
    parameter int PW    = 4,
    parameter int LW    = 5
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          clr_i,
    input logic          wr_en_i,
    input logic          rd_en_i,
    input logic          full_i,
    input logic          empty_i,
    input logic [PW-1:0] wptr_i,
    input logic [PW-1:0] rptr_i,
    input logic [LW-1:0] level_i
);

    a_wptr_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (wr_en_i && full_i && !clr_i) |=> $stable(wptr_i));

    a_rptr_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (rd_en_i && empty_i && !clr_i) |=> $stable(rptr_i));

    a_level_max: assert property (@(posedge clk_i) disable iff (rst_i)
        level_i <= LW'(DEPTH));

    a_full_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(full_i && empty_i));

endmodule

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
    output logic [WIDTH-1:0]          o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // storage write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_level.sv
// Synchronous FIFO with fill level, almost-full/empty thresholds, sticky error flags,
// flush, and standard or first-word-fall-through read.
module fifo_level
    import fifo_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter int         DEPTH     = 16,
    parameter int         AF_THRESH = 12,
    parameter int         AE_THRESH = 2,
    parameter fifo_mode_e FWFT      = FIFO_STD
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic                      wr_en_i,
    output logic                      full_o,
    output logic                      almost_full_o,
    input  logic                      rd_en_i,
    output logic [WIDTH-1:0]          rdata_o,
    output logic                      empty_o,
    output logic                      almost_empty_o,
    output logic [level_w(DEPTH)-1:0] level_o,
    output logic                      overflow_o,
    output logic                      underflow_o
);

    localparam int LW = level_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    if (DEPTH < 2) begin : g_err_depth
        $error("fifo_level: DEPTH must be at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_err_af
        $error("fifo_level: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_err_ae
        $error("fifo_level: AE_THRESH must lie in 0..DEPTH-1");
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    logic [PW-1:0]    r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt, w_raddr;
    logic [LW-1:0]    r_level, w_level_nxt;
    logic             r_full, r_af, r_empty, r_ae, r_ovf, r_unf;
    logic [WIDTH-1:0] r_rdata, w_rdata_nxt, w_mem_rdata;
    logic             w_wr_acc, w_rd_acc, w_mem_we;

    assign w_wr_acc = wr_en_i & ~r_full;
    assign w_rd_acc = rd_en_i & ~r_empty;
    assign w_mem_we = w_wr_acc & ~clr_i;

    // next pointer and level values
    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_level_nxt = r_level;
        if (clr_i) begin
            w_wptr_nxt  = {PW{1'b0}};
            w_rptr_nxt  = {PW{1'b0}};
            w_level_nxt = {LW{1'b0}};
        end else begin
            w_wptr_nxt = w_wr_acc ? ptr_inc(r_wptr) : r_wptr;
            w_rptr_nxt = w_rd_acc ? ptr_inc(r_rptr) : r_rptr;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_level_nxt = r_level + LW'(1);
                2'b01:   w_level_nxt = r_level - LW'(1);
                default: w_level_nxt = r_level;
            endcase
        end
    end

    // FWFT looks one pointer ahead so the head word can be registered
    assign w_raddr = (FWFT == FIFO_FWFT) ? w_rptr_nxt : r_rptr;

    // next read-data register value; FWFT bypasses a word landing at the new head
    always_comb begin
        w_rdata_nxt = r_rdata;
        if (clr_i) begin
            w_rdata_nxt = {WIDTH{1'b0}};
        end else if (FWFT == FIFO_FWFT) begin
            if (w_level_nxt == LW'(0)) begin
                w_rdata_nxt = {WIDTH{1'b0}};
            end else if (w_wr_acc && (w_rptr_nxt == r_wptr)) begin
                w_rdata_nxt = wdata_i;
            end else begin
                w_rdata_nxt = w_mem_rdata;
            end
        end else if (w_rd_acc) begin
            w_rdata_nxt = w_mem_rdata;
        end else begin
            w_rdata_nxt = r_rdata;
        end
    end

    // control state, flags decoded from the next level, and output data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_level <= {LW{1'b0}};
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_empty <= 1'b1;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_rdata <= {WIDTH{1'b0}};
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_af    <= (w_level_nxt >= LW'(AF_THRESH));
            r_empty <= (w_level_nxt == LW'(0));
            r_ae    <= (w_level_nxt <= LW'(AE_THRESH));
            r_ovf   <= clr_i ? 1'b0 : (r_ovf | (wr_en_i & r_full));
            r_unf   <= clr_i ? 1'b0 : (r_unf | (rd_en_i & r_empty));
            r_rdata <= w_rdata_nxt;
        end
    end

    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .i_clk   (clk_i),
        .i_we    (w_mem_we),
        .i_waddr (r_wptr),
        .i_wdata (wdata_i),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_rdata)
    );

    fifo_level_chk #(.DEPTH(DEPTH), .PW(PW), .LW(LW)) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr_i),
        .wr_en_i (wr_en_i),
        .rd_en_i (rd_en_i),
        .full_i  (r_full),
        .empty_i (r_empty),
        .wptr_i  (r_wptr),
        .rptr_i  (r_rptr),
        .level_i (r_level)
    );

    assign full_o         = r_full;
    assign almost_full_o  = r_af;
    assign empty_o        = r_empty;
    assign almost_empty_o = r_ae;
    assign level_o        = r_level;
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_unf;
    assign rdata_o        = r_rdata;

endmodule

// File: tb/tb_fifo_level.sv
// Scoreboard bench: three FIFOs (16 std, 16 FWFT, 12 std) share stimulus and are checked
// every cycle against a word-log reference model.
module tb_fifo_level;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wdata = 32'h0;

    logic        full_s [3];
    logic        af_s [3];
    logic        empty_s [3];
    logic        ae_s [3];
    logic        ovf_s [3];
    logic        unf_s [3];
    logic [31:0] rdata_s [3];
    logic [4:0]  lvl0, lvl1;
    logic [3:0]  lvl2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_level #(.WIDTH(32), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(FIFO_STD)) u_std (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .wdata_i(wdata), .wr_en_i(wr_en),
        .full_o(full_s[0]), .almost_full_o(af_s[0]), .rd_en_i(rd_en), .rdata_o(rdata_s[0]),
        .empty_o(empty_s[0]), .almost_empty_o(ae_s[0]), .level_o(lvl0),
        .overflow_o(ovf_s[0]), .underflow_o(unf_s[0]));

    fifo_level #(.WIDTH(32), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(FIFO_FWFT)) u_fwft (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .wdata_i(wdata), .wr_en_i(wr_en),
        .full_o(full_s[1]), .almost_full_o(af_s[1]), .rd_en_i(rd_en), .rdata_o(rdata_s[1]),
        .empty_o(empty_s[1]), .almost_empty_o(ae_s[1]), .level_o(lvl1),
        .overflow_o(ovf_s[1]), .underflow_o(unf_s[1]));

    fifo_level #(.WIDTH(32), .DEPTH(12), .AF_THRESH(9), .AE_THRESH(2), .FWFT(FIFO_STD)) u_d12 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .wdata_i(wdata), .wr_en_i(wr_en),
        .full_o(full_s[2]), .almost_full_o(af_s[2]), .rd_en_i(rd_en), .rdata_o(rdata_s[2]),
        .empty_o(empty_s[2]), .almost_empty_o(ae_s[2]), .level_o(lvl2),
        .overflow_o(ovf_s[2]), .underflow_o(unf_s[2]));

    typedef struct packed {
        logic [4:0]  level;
        logic        full;
        logic        af;
        logic        empty;
        logic        ae;
        logic        ovf;
        logic        unf;
        logic [31:0] rdata;
    } obs_t;

    obs_t exp_q [$];

    // reference model: every accepted word is appended to a log; the FIFO is the span [mr, mw)
    int unsigned dep  [3] = '{16, 16, 12};
    int unsigned afth [3] = '{12, 12, 9};
    bit          fw   [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] mlog [3][8192];
    int unsigned mw [3];
    int unsigned mr [3];
    bit          movf [3];
    bit          munf [3];
    logic [31:0] mrd [3];

    function automatic void model_reset(input int i);
        mr[i] = mw[i];
        movf[i] = 1'b0;
        munf[i] = 1'b0;
        mrd[i] = 32'h0;
    endfunction

    function automatic void model_step(input int i, input logic w, r, c, input logic [31:0] d);
        int unsigned lv;
        bit wa, ra;
        if (c) begin
            model_reset(i);
            return;
        end
        lv = mw[i] - mr[i];
        wa = w && (lv < dep[i]);
        ra = r && (lv > 0);
        if (w && !wa) movf[i] = 1'b1;
        if (r && !ra) munf[i] = 1'b1;
        if (ra) begin
            mrd[i] = mlog[i][mr[i][12:0]];
            mr[i]++;
        end
        if (wa) begin
            mlog[i][mw[i][12:0]] = d;
            mw[i]++;
        end
    endfunction

    function automatic obs_t exp_obs(input int i);
        obs_t o;
        int unsigned lv = mw[i] - mr[i];
        o.level = 5'(lv);
        o.full  = (lv == dep[i]);
        o.af    = (lv >= afth[i]);
        o.empty = (lv == 0);
        o.ae    = (lv <= 2);
        o.ovf   = movf[i];
        o.unf   = munf[i];
        if (fw[i]) o.rdata = (lv != 0) ? mlog[i][mr[i][12:0]] : 32'h0;
        else       o.rdata = mrd[i];
        return o;
    endfunction

    function automatic obs_t act_obs(input int i);
        obs_t o;
        o.level = (i == 0) ? lvl0 : (i == 1) ? lvl1 : {1'b0, lvl2};
        o.full  = full_s[i];
        o.af    = af_s[i];
        o.empty = empty_s[i];
        o.ae    = ae_s[i];
        o.ovf   = ovf_s[i];
        o.unf   = unf_s[i];
        o.rdata = rdata_s[i];
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_obs(input string nm, input int i, input obs_t a, input obs_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s inst%0d got=%h exp=%h t=%0t", nm, i, a, e, $time);
        end
    endtask

    // called at a falling edge; applies one cycle of stimulus and queues the expected state
    task automatic drive(input logic w, input logic r, input logic c, input logic [31:0] d);
        wr_en = w;
        rd_en = r;
        clr   = c;
        wdata = d;
        for (int i = 0; i < 3; i++) begin
            model_step(i, w, r, c, d);
            exp_q.push_back(exp_obs(i));
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            model_reset(i);
            chk_obs("async_reset", i, act_obs(i), exp_obs(i));
            exp_q.push_back(exp_obs(i));
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // monitor: compares every instance against the queued expectation after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() >= 3) begin
                for (int i = 0; i < 3; i++) begin
                    chk_obs("sb", i, act_obs(i), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int pw;
        for (int i = 0; i < 3; i++) begin
            mw[i] = 0;
            model_reset(i);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 17; k++) drive(1'b1, 1'b0, 1'b0, 32'h1000_0000 + 32'(k));
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("fill_full", {31'h0, full_s[0]}, 32'd1);
        chk("fill_ovf", {31'h0, ovf_s[0]}, 32'd1);
        for (int k = 0; k < 17; k++) drive(1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("drain_unf", {31'h0, unf_s[0]}, 32'd1);

        drive(1'b0, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
        chk("fwft_head", rdata_s[1], 32'hA5A5_0001);
        chk("fwft_empty", {31'h0, empty_s[1]}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);

        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 1'b0, $urandom);
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b1, 1'b0, $urandom);
        chk("steady_level", {27'h0, lvl0}, 32'd8);
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 1'b0, $urandom);
        drive(1'b1, 1'b1, 1'b0, $urandom);
        chk("full_wr_rd_level", {27'h0, lvl0}, 32'd15);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("full_wr_rd_ovf", {31'h0, ovf_s[0]}, 32'd1);

        drive(1'b0, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, 1'b0, $urandom);
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD_0007);
        chk("clr_level", {27'h0, lvl0}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'hC0DE_0001);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("clr_new_word", rdata_s[0], 32'hC0DE_0001);

        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 1'b0, $urandom);
            for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 1'b0, 32'h0);
        end

        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 1'b0, $urandom);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        reset_pulse();

        pw = 50;
        for (int k = 0; k < 1500; k++) begin
            if (k % 250 == 0) pw = $urandom_range(20, 80);
            drive(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) >= pw),
                  ($urandom_range(0, 79) == 0), $urandom);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain pending=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
